// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a 3-port register file.
// One-cycle registered write stage; writes to R15 are diverted to the PC path.
module regfile_wr_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        ex_valid,
    input  logic [3:0]  ex_addr,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        ld_valid,
    input  logic [3:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        we3,
    output logic [3:0]  a3,
    output logic [31:0] wd3,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    input  logic [3:0]  chk_a1,
    input  logic [3:0]  chk_a2,
    output logic        haz1,
    output logic        haz2,
    output logic [7:0]  conflict_cnt
);

    typedef enum logic {
        GRANT_EX = 1'b0,
        GRANT_LD = 1'b1
    } grant_e;

    localparam logic [3:0] PC_ADDR = 4'd15;

    grant_e      r_last_grant;
    logic        r_we3;
    logic [3:0]  r_a3;
    logic [31:0] r_wd3;
    logic        r_pc_we;
    logic [31:0] r_pc_wd;
    logic [7:0]  r_conflict_cnt;

    logic        w_ex_grant;
    logic        w_ld_grant;
    logic        w_accept;
    logic        w_contend;
    logic [3:0]  w_addr;
    logic [31:0] w_data;

    // Ready doubles as grant; a grant always coincides with a valid, so it is an acceptance.
    always_comb begin
        w_ex_grant = 1'b0;
        w_ld_grant = 1'b0;
        if (!hold && !reset) begin
            if (ex_valid && ld_valid) begin
                if (r_last_grant == GRANT_LD) begin
                    w_ex_grant = 1'b1;
                end else begin
                    w_ld_grant = 1'b1;
                end
            end else begin
                w_ex_grant = ex_valid;
                w_ld_grant = ld_valid;
            end
        end
    end

    assign w_accept  = w_ex_grant || w_ld_grant;
    assign w_contend = ex_valid && ld_valid && !hold;
    assign w_addr    = w_ld_grant ? ld_addr : ex_addr;
    assign w_data    = w_ld_grant ? ld_data : ex_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant   <= GRANT_LD;
            r_we3          <= 1'b0;
            r_a3           <= '0;
            r_wd3          <= '0;
            r_pc_we        <= 1'b0;
            r_pc_wd        <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_we3   <= 1'b0;
            r_pc_we <= 1'b0;
            if (w_accept) begin
                if (w_addr == PC_ADDR) begin
                    r_pc_we <= 1'b1;
                    r_pc_wd <= w_data;
                end else begin
                    r_we3 <= 1'b1;
                    r_a3  <= w_addr;
                    r_wd3 <= w_data;
                end
                r_last_grant <= w_ld_grant ? GRANT_LD : GRANT_EX;
            end
            if (w_contend && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end
    end

    assign ex_ready     = w_ex_grant;
    assign ld_ready     = w_ld_grant;
    assign we3          = r_we3;
    assign a3           = r_a3;
    assign wd3          = r_wd3;
    assign pc_we        = r_pc_we;
    assign pc_wd        = r_pc_wd;
    assign conflict_cnt = r_conflict_cnt;

    // R15 reads are served by the PC, so they never collide with a regfile write.
    assign haz1 = r_we3 && (r_a3 == chk_a1) && (chk_a1 != PC_ADDR);
    assign haz2 = r_we3 && (r_a3 == chk_a2) && (chk_a2 != PC_ADDR);

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have ports as listed; one clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock shared with regfile
- reset  in  1  asynchronous, active-high
- hold  in  1  stall; no grants while high
- ex_valid  in  1  execute-stage write request
- ex_addr  in  4  execute destination register
- ex_data  in  32  execute result
- ex_ready  out  1  execute request accepted this cycle
- ld_valid  in  1  load-stage write request
- ld_addr  in  4  load destination register
- ld_data  in  32  load data
- ld_ready  out  1  load request accepted this cycle
- we3  out  1  regfile write enable
- a3  out  4  regfile write address
- wd3  out  32  regfile write data
- pc_we  out  1  write targeting R15, diverted to PC logic
- pc_wd  out  32  R15 write data
- chk_a1  in  4  regfile read address 1 being issued
- chk_a2  in  4  regfile read address 2 being issued
- haz1  out  1  read 1 collides with pending write
- haz2  out  1  read 2 collides with pending write
- conflict_cnt  out  8  saturating count of contended cycles

Function
REQ-002 SHALL accept a request when valid and ready are both high in the same cycle.
REQ-003 SHALL drive ex_ready and ld_ready combinationally from valids, hold and the priority pointer; never both high.
REQ-004 SHALL hold both readys low while hold=1 or reset=1.
REQ-005 Single valid requester with hold=0: that requester's ready SHALL be high.
REQ-006 Both valid with hold=0: SHALL grant the requester not granted most recently (round-robin, 1-bit last_grant).
REQ-007 last_grant SHALL update on every accepted request to the granted requester; unchanged otherwise.
REQ-008 Accepted request with addr!=15: next edge SHALL set we3=1, a3=addr, wd3=data, pc_we=0.
REQ-009 Accepted request with addr==15: next edge SHALL set pc_we=1, pc_wd=data, we3=0; regfile R15 is never written through we3.
REQ-010 No accepted request: next edge SHALL set we3=0 and pc_we=0; a3, wd3 and pc_wd hold their values.
REQ-011 Latency SHALL be exactly one cycle from acceptance to we3/pc_we; throughput one write per cycle.
REQ-012 haz1 SHALL equal we3 && (a3==chk_a1) && (chk_a1!=15), combinationally; haz2 likewise for chk_a2.
REQ-013 conflict_cnt SHALL increment by 1 on each edge where both valids are high and hold=0, and SHALL saturate at 255.
REQ-014 hold=1 with both valid SHALL NOT count as a conflict.
REQ-015 Requests not accepted SHALL NOT be buffered; requesters hold valid/addr/data until ready.

Reset
REQ-016 Asserting reset SHALL immediately force we3=0, pc_we=0, a3=0, wd3=0, pc_wd=0, conflict_cnt=0 and last_grant=LD, so EX wins the first contention.
REQ-017 A write pending in the output stage when reset asserts SHALL be discarded and never reach the regfile.
REQ-018 First grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-019 Reset, then ex_valid=1, ex_addr=3, ex_data=0x11111111 for one cycle -> ex_ready=1 that cycle; next cycle we3=1, a3=3, wd3=0x11111111; following cycle we3=0.
REQ-020 Both valid for 4 cycles (ex_addr=1, ld_addr=2) -> grants EX, LD, EX, LD; conflict_cnt=4.
REQ-021 ld_valid=1, ld_addr=15, ld_data=0x00000100 -> next cycle pc_we=1, pc_wd=0x00000100, we3=0.
REQ-022 we3=1, a3=5; chk_a1=5, chk_a2=6 -> haz1=1, haz2=0; a3=15 is never produced, and chk_a1=15 gives haz1=0.
REQ-023 hold=1 with both valid for 3 cycles -> both readys 0, we3=0, conflict_cnt unchanged. Then 300 contended cycles -> conflict_cnt=255.
REQ-024 Accept ex_addr=7 and assert reset mid-cycle before the next edge -> we3 stays 0, conflict_cnt=0; after release, both valid -> EX granted first.
